// File: rtl/mips_isa_pkg.sv
// MIPS opcode constants and instruction field positions, shared by the
// instruction encoder/loader and the control decoder.
package mips_isa_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0d;
  localparam logic [5:0] LUI    = 6'h0f;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;

  // Least-significant bit of each field within the 32-bit word.
  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

endpackage

// File: rtl/instr_format_encoder.sv
// Combinational packer: decoded MIPS fields to a 32-bit word, with a flag
// saying whether the opcode belongs to the supported set.
module instr_format_encoder
  import mips_isa_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        supported
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a latch.
    word      = '0;
    supported = 1'b0;
    word[OP_LSB +: 6] = op;
    case (op)
      R_TYPE: begin
        supported               = 1'b1;
        word[RS_LSB +: 5]       = rs;
        word[RT_LSB +: 5]       = rt;
        word[RD_LSB +: 5]       = rd;
        word[SHAMT_LSB +: 5]    = shamt;
        word[FUNCT_LSB +: 6]    = funct;
      end
      ADDI, ORI, BEQ, BNE, LW, SW: begin
        supported               = 1'b1;
        word[RS_LSB +: 5]       = rs;
        word[RT_LSB +: 5]       = rt;
        word[IMM_LSB +: 16]     = imm;
      end
      LUI: begin
        // rs slot stays zero regardless of the rs input.
        supported               = 1'b1;
        word[RT_LSB +: 5]       = rt;
        word[IMM_LSB +: 16]     = imm;
      end
      J: begin
        supported               = 1'b1;
        word[TARGET_LSB +: 26]  = target;
      end
      default: begin
        word      = '0;
        supported = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_mem_writer.sv
// Instruction loader: accepts decoded fields over valid/ready, encodes them
// and writes each word to instruction memory at an incrementing address.
module instr_mem_writer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            op,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [4:0]            shamt,
  input  logic [5:0]            funct,
  input  logic [15:0]           imm,
  input  logic [25:0]           target,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err_opcode
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FULL} state_t;

  state_t      state;
  state_t      nextState;
  logic [31:0] encWord;
  logic        encSupported;
  logic        accept;
  logic        lastAddr;
  logic        restart;

  instr_format_encoder encoder (
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .shamt     (shamt),
    .funct     (funct),
    .imm       (imm),
    .target    (target),
    .word      (encWord),
    .supported (encSupported)
  );

  // start is ignored in WRITE so a pending write always lands.
  assign restart  = start && (state != WRITE);
  assign accept   = (state == LOAD) && in_valid && !start;
  assign lastAddr = (mem_addr == ADDR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    full      = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (start)                        nextState = LOAD;
        else if (in_valid && encSupported) nextState = WRITE;
      end
      WRITE: begin
        mem_we    = 1'b1;
        nextState = lastAddr ? FULL : LOAD;
      end
      FULL: begin
        full = 1'b1;
        if (start) nextState = LOAD;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      count      <= '0;
      err_opcode <= 1'b0;
    end else if (restart) begin
      mem_addr   <= '0;
      count      <= '0;
      err_opcode <= 1'b0;
    end else if (accept) begin
      if (encSupported) mem_wdata  <= encWord;
      else              err_opcode <= 1'b1;
    end else if (state == WRITE) begin
      count <= count + (ADDR_WIDTH + 1)'(1);
      // The address saturates at the last word; FULL holds it there.
      if (!lastAddr) mem_addr <= mem_addr + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instr_mem_writer.sv
// Self-checking bench for instr_mem_writer (ADDR_WIDTH=2, DEPTH=4) with a
// field-level encoding model and a word-count scoreboard.
module tb_instr_mem_writer;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } fields_t;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [5:0]    op, funct;
  logic [4:0]    rs, rt, rd, shamt;
  logic [15:0]   imm;
  logic [25:0]   target;
  logic          in_ready, mem_we, full, err_opcode;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  int errors = 0;
  int checks = 0;

  instr_mem_writer #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .imm        (imm),
    .target     (target),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .count      (count),
    .full       (full),
    .err_opcode (err_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // Reference encoding: {supported, word} straight from the MIPS format rules.
  function automatic logic [32:0] refEncode(input fields_t f);
    case (f.op)
      6'h00:                             return {1'b1, f.op, f.rs, f.rt, f.rd, f.shamt, f.funct};
      6'h08, 6'h0d, 6'h04, 6'h05,
      6'h23, 6'h2b:                      return {1'b1, f.op, f.rs, f.rt, f.imm};
      6'h0f:                             return {1'b1, f.op, 5'd0, f.rt, f.imm};
      6'h02:                             return {1'b1, f.op, f.target};
      default:                           return 33'd0;
    endcase
  endfunction

  function automatic fields_t mk(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                                 input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [15:0] im, input logic [25:0] tg);
    fields_t f;
    f.op = o; f.rs = s; f.rt = t; f.rd = d; f.shamt = sh; f.funct = fn; f.imm = im; f.target = tg;
    return f;
  endfunction

  function automatic fields_t randFields();
    logic [5:0] supTab [9];
    fields_t f;
    supTab = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b};
    f.op     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : supTab[$urandom_range(0, 8)];
    f.rs     = 5'($urandom);
    f.rt     = 5'($urandom);
    f.rd     = 5'($urandom);
    f.shamt  = 5'($urandom);
    f.funct  = 6'($urandom);
    f.imm    = 16'($urandom);
    f.target = 26'($urandom);
    return f;
  endfunction

  task automatic setFields(input fields_t f);
    op = f.op; rs = f.rs; rt = f.rt; rd = f.rd;
    shamt = f.shamt; funct = f.funct; imm = f.imm; target = f.target;
  endtask

  task automatic pulseStart();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // One in_valid beat, then observe the following cycle (the WRITE cycle if accepted).
  task automatic transfer(input fields_t f, output logic we, output logic rdy,
                          output logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [AW:0] cntAfter);
    @(negedge clk); setFields(f); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    we = mem_we; rdy = in_ready; addr = mem_addr; data = mem_wdata;
    @(posedge clk); #1;
    cntAfter = count;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    setFields('0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0)     begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== '0)    begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (count !== '0)        begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (full !== 1'b0)       begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (err_opcode !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_opcode); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic_and_full();
    logic we, rdy; logic [AW-1:0] a; logic [31:0] d; logic [AW:0] c;
    logic [31:0] expW [4];
    logic [AW:0] expC;
    fields_t seq [4];
    expW = '{32'h20090005, 32'h012A4020, 32'h08100004, 32'h3C011001};
    seq[0] = mk(6'h08, 5'd0, 5'd9,  5'd3, 5'd7, 6'h11, 16'h0005, 26'h0);
    seq[1] = mk(6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'hBEEF, 26'h0);
    seq[2] = mk(6'h02, 5'd4, 5'd4,  5'd4, 5'd4, 6'h04, 16'h1234, 26'h0100004);
    seq[3] = mk(6'h0f, 5'd5, 5'd1,  5'd2, 5'd3, 6'h05, 16'h1001, 26'h3FFFFFF);
    pulseStart();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL start_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      transfer(seq[i], we, rdy, a, d, c);
      expC = (AW + 1)'(i + 1);
      checks++; if (we !== 1'b1)          begin errors++; $display("FAIL basic%0d_we: got %b want 1", i, we); end
      checks++; if (rdy !== 1'b0)         begin errors++; $display("FAIL basic%0d_ready_in_write: got %b want 0", i, rdy); end
      checks++; if (a !== AW'(i))         begin errors++; $display("FAIL basic%0d_addr: got %0d want %0d", i, a, i); end
      checks++; if (d !== expW[i])        begin errors++; $display("FAIL basic%0d_wdata: got %h want %h", i, d, expW[i]); end
      checks++; if (c !== expC)           begin errors++; $display("FAIL basic%0d_count: got %0d want %0d", i, c, i + 1); end
      checks++; if (mem_we !== 1'b0)      begin errors++; $display("FAIL basic%0d_we_pulse: got %b want 0", i, mem_we); end
    end
    checks++; if (full !== 1'b1)     begin errors++; $display("FAIL full_flag: got %b want 1", full); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_addr !== 2'd3) begin errors++; $display("FAIL full_addr_held: got %0d want 3", mem_addr); end
    transfer(seq[0], we, rdy, a, d, c);
    checks++; if (we !== 1'b0)  begin errors++; $display("FAIL full_ignore_we: got %b want 0", we); end
    checks++; if (c !== 3'd4)   begin errors++; $display("FAIL full_ignore_count: got %0d want 4", c); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_ignore_full: got %b want 1", full); end
    pulseStart();
    #1;
    checks++; if (count !== '0)      begin errors++; $display("FAIL restart_count: got %0d want 0", count); end
    checks++; if (mem_addr !== '0)   begin errors++; $display("FAIL restart_addr: got %0d want 0", mem_addr); end
    checks++; if (full !== 1'b0)     begin errors++; $display("FAIL restart_full: got %b want 0", full); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL restart_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_bad_opcode();
    logic we, rdy; logic [AW-1:0] a; logic [31:0] d; logic [AW:0] c;
    pulseStart();
    transfer(mk(6'h3F, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'h6666, 26'h1), we, rdy, a, d, c);
    checks++; if (we !== 1'b0)         begin errors++; $display("FAIL bad_op_we: got %b want 0", we); end
    checks++; if (err_opcode !== 1'b1) begin errors++; $display("FAIL bad_op_err: got %b want 1", err_opcode); end
    checks++; if (a !== '0)            begin errors++; $display("FAIL bad_op_addr: got %0d want 0", a); end
    checks++; if (c !== '0)            begin errors++; $display("FAIL bad_op_count: got %0d want 0", c); end
    transfer(mk(6'h08, 5'd0, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0), we, rdy, a, d, c);
    checks++; if (we !== 1'b1 || a !== '0 || d !== 32'h20090005)
      begin errors++; $display("FAIL after_bad_write: got we=%b addr=%0d data=%h want 1/0/20090005", we, a, d); end
    checks++; if (err_opcode !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_opcode); end
    // start and in_valid together in LOAD: start wins.
    @(negedge clk); start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL start_wins_we: got %b want 0", mem_we); end
    checks++; if (count !== '0)        begin errors++; $display("FAIL start_wins_count: got %0d want 0", count); end
    checks++; if (err_opcode !== 1'b0) begin errors++; $display("FAIL start_clears_err: got %b want 0", err_opcode); end
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    fields_t f;
    logic [32:0] e;
    pulseStart();
    @(negedge clk); in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      f = randFields();
      f.op = 6'h23;
      e = refEncode(f);
      setFields(f);
      @(posedge clk); #1;
      checks++; if (mem_we !== 1'b1 || mem_wdata !== e[31:0] || mem_addr !== AW'(i))
        begin errors++; $display("FAIL b2b%0d: got we=%b addr=%0d data=%h want 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, i, e[31:0]); end
      @(posedge clk); #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b%0d_gap: got %b want 0", i, mem_we); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (full !== 1'b1 || count !== 3'd4)
      begin errors++; $display("FAIL b2b_full: got full=%b count=%0d want 1/4", full, count); end
  endtask

  task automatic test_random();
    logic we, rdy; logic [AW-1:0] a; logic [31:0] d; logic [AW:0] c;
    fields_t f;
    logic [32:0] e;
    int  mCount;
    bit  mErr, wasFull, expWe;
    pulseStart();
    mCount = 0; mErr = 0;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        pulseStart();
        mCount = 0; mErr = 0;
      end
      f = randFields();
      e = refEncode(f);
      wasFull = (mCount == DEPTH);
      expWe = e[32] && !wasFull;
      transfer(f, we, rdy, a, d, c);
      checks++; if (we !== expWe) begin errors++; $display("FAIL rand%0d_we: op=%h got %b want %b", n, f.op, we, expWe); end
      if (expWe) begin
        checks++; if (a !== AW'(mCount) || d !== e[31:0])
          begin errors++; $display("FAIL rand%0d_write: got addr=%0d data=%h want %0d/%h", n, a, d, mCount, e[31:0]); end
        mCount++;
      end else if (!wasFull) begin
        mErr = 1;
      end
      checks++; if (c !== (AW + 1)'(mCount)) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", n, c, mCount); end
      checks++; if (err_opcode !== mErr)     begin errors++; $display("FAIL rand%0d_err: got %b want %b", n, err_opcode, mErr); end
      checks++; if (full !== (mCount == DEPTH)) begin errors++; $display("FAIL rand%0d_full: got %b want %b", n, full, mCount == DEPTH); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic we, rdy; logic [AW-1:0] a; logic [31:0] d; logic [AW:0] c;
    pulseStart();
    @(negedge clk); setFields(mk(6'h0d, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hA5A5, 26'h0)); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL midwrite_pre_we: got %b want 1", mem_we); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midwrite_we_async: got %b want 0", mem_we); end
    checks++; if ({in_ready, mem_addr, mem_wdata, count, full, err_opcode} !== '0)
      begin errors++; $display("FAIL midwrite_outputs: got rdy=%b addr=%0d data=%h cnt=%0d full=%b err=%b want all 0",
                               in_ready, mem_addr, mem_wdata, count, full, err_opcode); end
    @(negedge clk); reset = 1'b0;
    transfer(mk(6'h08, 5'd0, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0), we, rdy, a, d, c);
    checks++; if (we !== 1'b0 || rdy !== 1'b0 || c !== '0)
      begin errors++; $display("FAIL idle_ignores_valid: got we=%b rdy=%b cnt=%0d want 0/0/0", we, rdy, c); end
    pulseStart();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_start_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_and_full();
    test_bad_opcode();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
